// File: rtl/tx_link_sched.sv
// Link-layer transmit scheduler: alignment commas, round-robin packet arbitration,
// periodic skip bursts, and running-disparity checking of returned 10b codes.
module tx_link_sched #(
  parameter int unsigned ALIGN_COUNT   = 4,
  parameter int unsigned SKIP_INTERVAL = 256,
  parameter int unsigned SKIP_LEN      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link_en,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_k,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_k,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       enc_valid,
  output logic [7:0] enc_data,
  output logic       enc_k,
  input  logic       enc_ready,
  input  logic [9:0] enc_code,
  input  logic       enc_code_valid,
  output logic       rd_out,
  output logic       disp_err,
  output logic [7:0] err_cnt,
  output logic       aligned,
  output logic [2:0] state_o
);

  localparam int unsigned ACW = $clog2(ALIGN_COUNT + 1);
  localparam int unsigned KCW = $clog2(SKIP_LEN + 1);
  localparam int unsigned SCW = $clog2(SKIP_INTERVAL + 1);
  localparam int unsigned BCW = (ACW > KCW) ? ACW : KCW;
  localparam logic [7:0]  COMMA = 8'hBC;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ARB   = 3'd2,
    S_SEND  = 3'd3,
    S_SKIP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_gnt_q, last_gnt_d;
  logic [BCW-1:0]   burst_q, burst_d;
  logic [SCW-1:0]   sym_cnt_q, sym_cnt_d;
  logic             aligned_q, aligned_d;
  logic             pend_q, pend_d;
  logic             rd_q, rd_d;
  logic             disp_err_q, disp_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             g_valid, g_k, g_last;
  logic [7:0]       g_data;
  logic             any_req, skip_due, offer, pick;
  logic [SCW-1:0]   sym_inc;
  logic [3:0]       pop;

  // Granted requester mux
  always_comb begin
    g_valid = req0_valid;
    g_data  = req0_data;
    g_k     = req0_k;
    g_last  = req0_last;
    if (gnt_q) begin
      g_valid = req1_valid;
      g_data  = req1_data;
      g_k     = req1_k;
      g_last  = req1_last;
    end
  end

  assign any_req  = req0_valid | req1_valid;
  assign skip_due = (sym_cnt_q == SCW'(SKIP_INTERVAL));
  assign sym_inc  = skip_due ? sym_cnt_q : sym_cnt_q + SCW'(1);
  assign pick     = (req0_valid && req1_valid) ? ~last_gnt_q : req1_valid;

  // Scheduler next-state and stream outputs
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    burst_d    = burst_q;
    sym_cnt_d  = sym_cnt_q;
    aligned_d  = aligned_q;
    pend_d     = 1'b0;
    offer      = 1'b0;
    enc_valid  = 1'b0;
    enc_data   = COMMA;
    enc_k      = 1'b1;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        sym_cnt_d = '0;
        burst_d   = '0;
        if (link_en) state_d = S_ALIGN;
      end

      S_ALIGN: begin
        enc_valid = 1'b1;
        if (enc_ready) begin
          if (!link_en) begin
            state_d = S_IDLE;
          end else if (burst_q == BCW'(ALIGN_COUNT - 1)) begin
            state_d   = S_ARB;
            aligned_d = 1'b1;
            burst_d   = '0;
          end else begin
            burst_d = burst_q + BCW'(1);
          end
        end
      end

      S_ARB: begin
        // A comma already offered must stay up until it is taken
        offer = pend_q || !any_req;
        if (!link_en) begin
          enc_valid = offer;
          if (!offer || enc_ready) state_d = S_IDLE;
          else                     pend_d  = 1'b1;
        end else if (skip_due) begin
          enc_valid = pend_q;
          state_d   = S_SKIP;
          sym_cnt_d = '0;
          burst_d   = '0;
        end else begin
          enc_valid = offer;
          if (offer && enc_ready) sym_cnt_d = sym_inc;
          if (any_req && (!pend_q || enc_ready)) begin
            gnt_d      = pick;
            last_gnt_d = pick;
            state_d    = S_SEND;
          end else if (offer && !enc_ready) begin
            pend_d = 1'b1;
          end
        end
      end

      S_SEND: begin
        enc_valid = g_valid;
        if (g_valid) begin
          enc_data = g_data;
          enc_k    = g_k;
        end
        req0_ready = !gnt_q && enc_ready;
        req1_ready =  gnt_q && enc_ready;
        if (g_valid && enc_ready) begin
          sym_cnt_d = sym_inc;
          if (g_last) state_d = link_en ? S_ARB : S_IDLE;
        end
      end

      S_SKIP: begin
        enc_valid = 1'b1;
        if (enc_ready) begin
          if (!link_en) begin
            state_d = S_IDLE;
          end else if (burst_q == BCW'(SKIP_LEN - 1)) begin
            state_d = S_ARB;
            burst_d = '0;
          end else begin
            burst_d = burst_q + BCW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) aligned_d = 1'b0;
  end

  // Running-disparity checker, independent of the scheduler
  always_comb begin
    pop        = '0;
    rd_d       = rd_q;
    disp_err_d = disp_err_q;
    err_cnt_d  = err_cnt_q;
    for (int i = 0; i < 10; i++) pop = pop + 4'(enc_code[i]);
    if (enc_code_valid) begin
      if (pop == 4'd5) begin
        rd_d = rd_q;
      end else if (pop == 4'd6 && rd_q) begin
        rd_d = 1'b0;
      end else if (pop == 4'd4 && !rd_q) begin
        rd_d = 1'b1;
      end else begin
        rd_d       = ~rd_q;
        disp_err_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      burst_q    <= '0;
      sym_cnt_q  <= '0;
      aligned_q  <= 1'b0;
      pend_q     <= 1'b0;
      rd_q       <= 1'b1;
      disp_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      burst_q    <= burst_d;
      sym_cnt_q  <= sym_cnt_d;
      aligned_q  <= aligned_d;
      pend_q     <= pend_d;
      rd_q       <= rd_d;
      disp_err_q <= disp_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rd_out   = rd_q;
  assign disp_err = disp_err_q;
  assign err_cnt  = err_cnt_q;
  assign aligned  = aligned_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_tx_link_sched.sv
// Directed bench for tx_link_sched: alignment, round-robin, skip bursts,
// back-pressure with link drop, disparity checking and reset abort.
module tb_tx_link_sched;

  logic       clk = 1'b0;
  logic       rst, link_en;
  logic       req0_valid, req0_k, req0_last, req0_ready;
  logic       req1_valid, req1_k, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       enc_valid, enc_k, enc_ready;
  logic [7:0] enc_data;
  logic [9:0] enc_code;
  logic       enc_code_valid;
  logic       rd_out, disp_err, aligned;
  logic [7:0] err_cnt;
  logic [2:0] state_o;

  tx_link_sched dut (
    .clk(clk), .rst(rst), .link_en(link_en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_k(req0_k),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_k(req1_k),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .enc_valid(enc_valid), .enc_data(enc_data), .enc_k(enc_k), .enc_ready(enc_ready),
    .enc_code(enc_code), .enc_code_valid(enc_code_valid),
    .rd_out(rd_out), .disp_err(disp_err), .err_cnt(err_cnt),
    .aligned(aligned), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Requester models: 3-symbol packets, req0 = 10,11,12 and req1 = 20,21,22
  logic src_en0, src_en1, hs0, hs1;
  int   idx0, idx1;
  assign req0_valid = src_en0;
  assign req1_valid = src_en1;
  assign req0_data  = 8'h10 + 8'(idx0);
  assign req1_data  = 8'h20 + 8'(idx1);
  assign req0_k     = 1'b0;
  assign req1_k     = 1'b0;
  assign req0_last  = (idx0 == 2);
  assign req1_last  = (idx1 == 2);

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic [2:0] st;
    logic       last;
  } xfer_t;
  xfer_t log_q[$];

  // Transfer monitor, sampled mid-cycle
  always @(negedge clk) begin
    xfer_t e;
    if (!rst && enc_valid && enc_ready) begin
      e.data = enc_data;
      e.k    = enc_k;
      e.st   = state_o;
      e.last = req0_ready ? req0_last : req1_last;
      log_q.push_back(e);
    end
    hs0 = !rst && req0_valid && req0_ready;
    hs1 = !rst && req1_valid && req1_ready;
  end

  always @(posedge clk) begin
    if (rst) begin
      idx0 <= 0;
      idx1 <= 0;
    end else begin
      if (hs0) idx0 <= (idx0 == 2) ? 0 : idx0 + 1;
      if (hs1) idx1 <= (idx1 == 2) ? 0 : idx1 + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; link_en = 1'b0; src_en0 = 1'b0; src_en1 = 1'b0;
    enc_ready = 1'b1; enc_code = '0; enc_code_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (state_o !== st && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(state_o), 32'(st));
  endtask

  typedef struct {
    logic [9:0] code;
    logic       valid;
    logic       exp_rd;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } dvec_t;
  dvec_t dv[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, nskip, seg_send, run, pkt, pos, other;
    logic in_skip;
    logic [7:0] exp_d;
    logic ok;

    dv[0] = '{10'h283, 1'b1, 1'b0, 1'b1, 8'd1};
    dv[1] = '{10'h17C, 1'b1, 1'b1, 1'b1, 8'd2};
    dv[2] = '{10'h17C, 1'b1, 1'b0, 1'b1, 8'd2};
    dv[3] = '{10'h283, 1'b1, 1'b1, 1'b1, 8'd2};
    dv[4] = '{10'h0F8, 1'b1, 1'b1, 1'b1, 8'd2};
    dv[5] = '{10'h3FF, 1'b0, 1'b1, 1'b1, 8'd2};
    dv[6] = '{10'h3FF, 1'b1, 1'b0, 1'b1, 8'd3};
    dv[7] = '{10'h000, 1'b1, 1'b1, 1'b1, 8'd4};

    // Reset state
    do_reset();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_valid", 32'(enc_valid), 32'd0);
    chk("rst_comma", {enc_data, enc_k}, {8'hBC, 1'b1});
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    chk("rst_aligned", 32'(aligned), 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd1);
    chk("rst_disp", {disp_err, err_cnt}, 9'd0);

    // Alignment with no requests, then idle commas
    log_q.delete();
    link_en = 1'b1;
    tick();
    wait_state(3'd2, 20, "align_to_arb");
    chk("align_count", 32'(log_q.size()), 32'd4);
    ok = 1'b1;
    foreach (log_q[i]) if (log_q[i].data != 8'hBC || !log_q[i].k || log_q[i].st != 3'd1) ok = 1'b0;
    chk("align_commas", 32'(ok), 32'd1);
    chk("aligned_set", 32'(aligned), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("idle_comma", {state_o, enc_valid, enc_data, enc_k}, {3'd2, 1'b1, 8'hBC, 1'b1});
      tick();
    end
    chk("idle_xfers", 32'(log_q.size()), 32'd10);

    // Round-robin packets with skip bursts
    do_reset();
    src_en0 = 1'b1; src_en1 = 1'b1; link_en = 1'b1;
    wait_state(3'd3, 20, "rr_first_send");
    log_q.delete();
    repeat (800) tick();
    nskip = 0; seg_send = 0; run = 0; pkt = 0; pos = 0; other = 0; in_skip = 1'b0;
    foreach (log_q[i]) begin
      if (log_q[i].st == 3'd3) begin
        if (in_skip) begin
          chk("skip_len", 32'(run), 32'd2);
          in_skip = 1'b0;
        end
        exp_d = ((pkt % 2) != 0) ? 8'h20 : 8'h10;
        exp_d = exp_d + 8'(pos);
        chk("rr_symbol", {log_q[i].data, log_q[i].k, log_q[i].last},
            {exp_d, 1'b0, pos == 2});
        seg_send++;
        pos++;
        if (pos == 3) begin
          pos = 0;
          pkt++;
        end
      end else if (log_q[i].st == 3'd4) begin
        if (!in_skip) begin
          in_skip = 1'b1;
          run = 0;
          nskip++;
          chk("skip_spacing", 32'(seg_send), 32'd258);
          chk("skip_boundary", 32'(pos), 32'd0);
          seg_send = 0;
        end
        chk("skip_comma", {log_q[i].data, log_q[i].k}, {8'hBC, 1'b1});
        run++;
      end else begin
        other++;
      end
    end
    chk("skip_bursts", 32'(nskip >= 2), 32'd1);
    chk("rr_no_idle", 32'(other), 32'd0);

    // Back-pressure mid-packet and link drop
    do_reset();
    src_en0 = 1'b1; link_en = 1'b1;
    n0 = 0;
    while (!(state_o == 3'd3 && req0_data == 8'h11) && n0 < 30) begin
      tick();
      n0++;
    end
    chk("stall_reach", {state_o, req0_data}, {3'd3, 8'h11});
    enc_ready = 1'b0;
    n0 = log_q.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) link_en = 1'b0;
      chk("stall_hold", {state_o, enc_valid, enc_data, enc_k, req0_ready},
          {3'd3, 1'b1, 8'h11, 1'b0, 1'b0});
    end
    enc_ready = 1'b1;
    tick();
    wait_state(3'd0, 10, "drop_to_idle");
    chk("drop_xfers", 32'(log_q.size()), 32'(n0 + 2));
    if (log_q.size() >= n0 + 2) begin
      chk("drop_sym1", {log_q[n0].data, log_q[n0].last}, {8'h11, 1'b0});
      chk("drop_sym2", {log_q[n0+1].data, log_q[n0+1].last}, {8'h12, 1'b1});
    end
    repeat (3) tick();
    chk("idle_after_drop", {state_o, enc_valid, aligned}, {3'd0, 1'b0, 1'b0});
    chk("idle_no_xfer", 32'(log_q.size()), 32'(n0 + 2));

    // Disparity checker table
    do_reset();
    foreach (dv[i]) begin
      enc_code = dv[i].code;
      enc_code_valid = dv[i].valid;
      tick();
      chk($sformatf("disp_vec%0d", i), {rd_out, disp_err, err_cnt},
          {dv[i].exp_rd, dv[i].exp_err, dv[i].exp_cnt});
    end
    enc_code = 10'h3FF;
    enc_code_valid = 1'b1;
    repeat (260) tick();
    enc_code_valid = 1'b0;
    tick();
    chk("err_sat", {rd_out, disp_err, err_cnt}, {1'b1, 1'b1, 8'd255});

    // Reset in SEND aborts the packet
    do_reset();
    src_en0 = 1'b1; link_en = 1'b1;
    enc_code = 10'h283; enc_code_valid = 1'b1;
    tick();
    enc_code_valid = 1'b0;
    wait_state(3'd3, 20, "pre_rst_send");
    chk("pre_rst_err", {rd_out, err_cnt}, {1'b0, 8'd1});
    rst = 1'b1;
    tick();
    chk("rst_send_state", {state_o, enc_valid, req0_ready}, {3'd0, 1'b0, 1'b0});
    chk("rst_send_disp", {rd_out, disp_err, err_cnt, aligned}, {1'b1, 1'b0, 8'd0, 1'b0});
    rst = 1'b0;
    link_en = 1'b0;
    n0 = log_q.size();
    repeat (4) tick();
    chk("rst_abort", {32'(log_q.size()), 29'd0, state_o}, {32'(n0), 29'd0, 3'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_link_sched.md
TX_LINK_SCHED -- requirements
Module: tx_link_sched

Interface
REQ-001 SHALL have parameter ALIGN_COUNT, default 4, giving the number of K28.5 commas sent after link enable.
REQ-002 SHALL have parameter SKIP_INTERVAL, default 256, giving the symbol count after which a skip burst is due.
REQ-003 SHALL have parameter SKIP_LEN, default 2, giving the number of K28.5 symbols per skip burst.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have port link_en in 1: link enable.
REQ-006 SHALL have ports reqN_valid in 1, reqN_data in 8, reqN_k in 1, reqN_last in 1, reqN_ready out 1, for N=0,1 (packet requesters).
REQ-007 SHALL have ports enc_valid out 1, enc_data out 8, enc_k out 1, enc_ready in 1: symbol stream to the 8b10b encoder.
REQ-008 SHALL have ports enc_code in 10, enc_code_valid in 1: 10b codes returned by the encoder for disparity checking.
REQ-009 SHALL have ports rd_out out 1 (1=RD-, 0=RD+), disp_err out 1 (sticky), err_cnt out 8, aligned out 1, state_o out 3.

Function
REQ-010 SHALL define a transfer as enc_valid && enc_ready in one cycle; a comma is enc_data=8'hBC with enc_k=1.
REQ-011 SHALL implement the FSM IDLE=0, ALIGN=1, ARB=2, SEND=3, SKIP=4 and reflect the current state on state_o.
REQ-012 SHALL, in IDLE, drive enc_valid=0 and both reqN_ready=0; it SHALL go to ALIGN when link_en=1.
REQ-013 SHALL, in ALIGN, drive commas and go to ARB on the ALIGN_COUNT-th comma transfer; aligned SHALL be 1 from that transition until IDLE is re-entered.
REQ-014 SHALL, in ARB with no reqN_valid, drive an idle comma.
REQ-015 SHALL, in ARB with a request pending, grant round-robin: requester 0 wins on the first arbitration after reset, and on a conflict the requester not granted last wins. The grant is registered and the next cycle enters SEND.
REQ-016 SHALL, in SEND, connect the granted requester combinationally: enc_valid=reqG_valid, enc_data=reqG_data, enc_k=reqG_k, reqG_ready=enc_ready. The other reqN_ready SHALL be 0.
REQ-017 SHALL leave SEND to ARB only on a transfer with reqG_last=1; packets are never interleaved or preempted.
REQ-018 SHALL, once enc_valid=1 is driven from ALIGN, ARB or SKIP, hold enc_valid, enc_data and enc_k stable until a transfer occurs.
REQ-019 SHALL keep a symbol counter sym_cnt, incremented per transfer in SEND and ARB and saturating at SKIP_INTERVAL; it is cleared on entry to SKIP and in IDLE.
REQ-020 SHALL, in ARB with sym_cnt==SKIP_INTERVAL, enter SKIP instead of granting; SKIP drives SKIP_LEN commas, then returns to ARB.
REQ-021 SHALL, when link_en=0 in ALIGN, ARB or SKIP, go to IDLE on the next transfer, or immediately if enc_valid=0. In SEND it SHALL finish the packet (last transfer), then go to IDLE.
REQ-022 SHALL keep rd (driven on rd_out) updated on each enc_code_valid from p = popcount(enc_code): p=5 leaves rd unchanged; p=6 with rd=1 sets rd=0; p=4 with rd=0 sets rd=1.
REQ-023 SHALL treat any other enc_code_valid case as an error: set disp_err=1 (sticky), increment err_cnt saturating at 255, and toggle rd (resync).
REQ-024 SHALL give the disparity checker priority over nothing else; it runs in all states, independently of the FSM.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, set state IDLE, enc_valid=0, reqN_ready=0, aligned=0, sym_cnt=0, rd=1, disp_err=0, err_cnt=0, and last-grant so that requester 0 wins first.
REQ-026 SHALL abort any packet or burst in progress when rst is asserted, with no completion of that packet.
REQ-027 SHALL drive enc_data=8'hBC and enc_k=1 whenever enc_valid=0.

Verification
REQ-028 Bench SHALL check: link_en=1, enc_ready=1, no requests -> 4 comma transfers, then aligned=1, state_o=2, continuous idle commas.
REQ-029 Bench SHALL check: both requesters continuously request 3-symbol packets -> grants alternate 0,1,0,1 with packets contiguous and uninterleaved.
REQ-030 Bench SHALL check: 256 symbols sent, then a packet boundary -> exactly 2 commas in SKIP before the next grant, and sym_cnt restarts.
REQ-031 Bench SHALL check: enc_ready=0 for 5 cycles mid-packet, and link_en dropped mid-packet -> enc_data is held stable, the packet completes, then IDLE.
REQ-032 Bench SHALL check: enc_code sequence 0x283 (p=4, at RD-) -> disp_err=1, err_cnt=1, rd toggles; then 0x17C (p=6, rd=0... RD+) -> err_cnt=2.
REQ-033 Bench SHALL check: rst asserted in SEND -> next cycle state_o=0, enc_valid=0, rd_out=1, err_cnt=0.
